// File: rtl/uart_tx_sched.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART transmitter among
//               NUM_REQ byte producers. Accepts one byte per frame, launches
//               the transmitter with a one-cycle active-low load strobe, waits
//               for the end-of-frame pulse (or a timeout) and enforces an
//               inter-frame gap before serving the next requester.
//
// Ports       : clk_input    - clock, rising edge
//               rst_input    - asynchronous active-high reset
//               req_valid    - per-requester byte pending
//               req_data     - byte of requester i on [8i+7:8i]
//               req_ready    - one-hot, one-cycle accept pulse
//               tx_data      - byte presented to the transmitter
//               tx_load_n    - active-low launch strobe (one cycle)
//               tx_done_n    - transmitter end-of-frame, active-low pulse
//               baud_rate    - constant baud divisor (BAUD_DIV)
//               grant_id     - requester served last or currently
//               busy         - high whenever not idle
//               frame_done   - one-cycle pulse on normal frame completion
//               timeout_err  - one-cycle pulse when a frame is abandoned
//
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx_sched #(
    parameter int          NUM_REQ    = 4,
    parameter logic [31:0] BAUD_DIV   = 32'd867,
    parameter logic [31:0] TIMEOUT    = 32'd20000,
    parameter int          GAP_CYCLES = 2
) (
    input  logic                   clk_input,
    input  logic                   rst_input,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_load_n,
    input  logic                   tx_done_n,
    output logic [31:0]            baud_rate,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    // Gap counter only needs to reach GAP_CYCLES-1
    localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    // After reset the pointer sits on the last requester so requester 0 wins
    localparam logic [2:0]  c_LAST_RST    = 3'(NUM_REQ - 1);
    localparam logic [31:0] c_TIMER_LAST  = TIMEOUT - 32'd1;
    localparam logic [31:0] c_TIMER_MAX   = 32'hFFFF_FFFF;

    // Registered state
    logic [1:0]          r_state;
    logic [7:0]          r_tx_data;
    logic                r_tx_load_n;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [2:0]          r_grant;
    logic [2:0]          r_last;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_timeout_err;
    logic [31:0]         r_timer;
    logic [c_GAP_W-1:0]  r_gap_cnt;

    // Next-state values
    logic [1:0]          w_state_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_tx_load_n_nxt;
    logic [NUM_REQ-1:0]  w_req_ready_nxt;
    logic [2:0]          w_grant_nxt;
    logic [2:0]          w_last_nxt;
    logic                w_frame_done_nxt;
    logic                w_timeout_err_nxt;
    logic [31:0]         w_timer_nxt;
    logic [c_GAP_W-1:0]  w_gap_cnt_nxt;

    // Round-robin pick results
    logic                w_found;
    logic [2:0]          w_sel;
    logic [NUM_REQ-1:0]  w_sel_oh;
    logic [7:0]          w_sel_byte;
    logic [3:0]          w_idx;

    //--------------------------------------------------------------------------
    // Round-robin arbiter: scan offsets 1..NUM_REQ from the last grant,
    // wrapping modulo NUM_REQ (which need not be a power of two). The first
    // set request along that order wins.
    //--------------------------------------------------------------------------
    always_comb begin
        w_found    = 1'b0;
        w_sel      = 3'd0;
        w_sel_oh   = '0;
        w_sel_byte = 8'd0;
        w_idx      = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_last} + 4'(k);
            if (w_idx >= 4'(NUM_REQ)) begin
                w_idx = w_idx - 4'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && (w_idx == 4'(i)) && req_valid[i]) begin
                    w_found    = 1'b1;
                    w_sel      = 3'(i);
                    w_sel_oh[i] = 1'b1;
                    w_sel_byte = req_data[8*i +: 8];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is computed one cycle
    // ahead and registered, so nothing combinational reaches a port.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_tx_data_nxt     = r_tx_data;
        w_tx_load_n_nxt   = 1'b1;
        w_req_ready_nxt   = '0;
        w_grant_nxt       = r_grant;
        w_last_nxt        = r_last;
        w_frame_done_nxt  = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_timer_nxt       = r_timer;
        w_gap_cnt_nxt     = r_gap_cnt;

        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = c_ST_LOAD;
                    w_tx_data_nxt   = w_sel_byte;
                    w_grant_nxt     = w_sel;
                    w_last_nxt      = w_sel;
                    w_req_ready_nxt = w_sel_oh;
                    w_tx_load_n_nxt = 1'b0;
                end
            end

            c_ST_LOAD: begin
                w_timer_nxt = 32'd0;
                w_state_nxt = c_ST_WAIT;
            end

            c_ST_WAIT: begin
                if (r_timer != c_TIMER_MAX) begin
                    w_timer_nxt = r_timer + 32'd1;
                end
                // A done pulse in the same cycle as the timeout takes priority
                if (!tx_done_n) begin
                    w_frame_done_nxt = 1'b1;
                    w_gap_cnt_nxt    = '0;
                    w_state_nxt      = c_ST_GAP;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_gap_cnt_nxt     = '0;
                    w_state_nxt       = c_ST_GAP;
                end
            end

            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_GAP_ONE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_input or posedge rst_input) begin
        if (rst_input) begin
            r_state       <= c_ST_IDLE;
            r_tx_data     <= 8'd0;
            r_tx_load_n   <= 1'b1;
            r_req_ready   <= '0;
            r_grant       <= 3'd0;
            r_last        <= c_LAST_RST;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timer       <= 32'd0;
            r_gap_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_load_n   <= w_tx_load_n_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_grant       <= w_grant_nxt;
            r_last        <= w_last_nxt;
            r_busy        <= (w_state_nxt != c_ST_IDLE);
            r_frame_done  <= w_frame_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_timer       <= w_timer_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_data     = r_tx_data;
    assign tx_load_n   = r_tx_load_n;
    assign baud_rate   = BAUD_DIV;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
